nios_system_mult_arbiter: RTL and testbench
===========================================

// Module: nios_system_mult_arbiter
// PURPOSE
//  Round-robin arbiter/sequencer sharing one 32x32 multiply cell (two 16x16 hard multipliers,
//  low-32-bit result, registered multiplier stage) among NUM_REQ requesters (CPU custom path,
//  MFCC/feature engines). Accepts at most one multiply per clock, drives the cell operands from a
//  registered issue stage, tracks in-flight ops with a one-hot tag pipeline, routes results back.
// PARAMETERS
//  NUM_REQ      4  number of requesters (2..8)
//  MUL_LATENCY  1  clocks from cell operand change to valid mul_result (cell pipeline depth)
//  FIXED_PRIO   0  0 = round-robin; 1 = fixed priority, lowest index wins
// PORTS
//  clk          in   1            system clock
//  reset_n      in   1            asynchronous active-low reset
//  req          in   NUM_REQ      request per requester; held with stable operands until gnt
//  req_a        in   32*NUM_REQ   multiplicand, requester i at [32*i+31:32*i]
//  req_b        in   32*NUM_REQ   multiplier, same packing
//  gnt          out  NUM_REQ      one-hot accept strobe, combinational, same cycle as req
//  rsp_valid    out  NUM_REQ      one-hot result strobe, one cycle per accepted op
//  rsp_data     out  32           product low 32 bits; 0 when no rsp_valid bit set
//  mul_src1     out  32           to cell A_mul_src1 (registered)
//  mul_src2     out  32           to cell A_mul_src2 (registered)
//  mul_result   in   32           from cell A_mul_cell_result
//  cnt_clear    in   1            synchronous clear of issue_count
//  issue_count  out  32           count of accepted ops, wraps 0xFFFFFFFF->0
// BEHAVIOUR
//  Reset (reset_n low, async): mul_src1/2=0, tag pipe=0, rr pointer=NUM_REQ-1, issue_count=0;
//   gnt=0, rsp_valid=0, rsp_data=0 while reset_n low regardless of req.
//  Arbitration (cycle T): if any req, exactly one gnt bit set. RR: search starts at ptr+1 mod
//   NUM_REQ, first set req wins; ptr <= winner on grant, unchanged when idle. FIXED_PRIO=1:
//   lowest set index wins, ptr unused. No req -> gnt=0.
//  Issue (edge ending T): mul_src1/2 <= req_a/req_b of winner; tag[0] <= gnt. No grant: operands
//   hold previous value (saves toggling), tag[0] <= 0.
//  Tag pipe: depth MUL_LATENCY+1, shifts every clock, no stall (cell ena tied high).
//  Response: rsp_valid = tag[MUL_LATENCY]; op granted in T returns in T+1+MUL_LATENCY.
//   rsp_data = mul_result when |rsp_valid else 0. Requester must accept; no backpressure.
//  Arithmetic: unsigned, modulo 2^32 (cell low half only); signed low 32 bits identical.
//  Throughput: one op/clock sustained; back-to-back grants to same requester allowed if it
//   re-raises req (RR still rotates when others request).
//  Requester dropping req before gnt: legal, no op issued, no response.
//  issue_count: +1 per cycle with any gnt; cnt_clear has priority over increment (result 0);
//   wraps silently.
//  Reset mid-operation: all in-flight ops dropped, no rsp_valid after reset release for them;
//   first grant after release goes to lowest-index requester (ptr=NUM_REQ-1).
//  Invariants: $onehot0(gnt), $onehot0(rsp_valid), gnt&~req==0.
// TESTING
//  1 req[0] a=3 b=5 in cycle 10 -> gnt[0]@10, rsp_valid[0]@12, rsp_data=15, issue_count=1.
//  2 req[1] a=0xFFFFFFFF b=0xFFFFFFFF -> rsp_data=0x00000001; a=0x00012345 b=0x00010000 -> 0x23450000.
//  3 all four req held 8 cycles after reset -> gnt order 0,1,2,3,0,1,2,3; rsp_valid same order,
//    2 cycles later, each with own product (a=i+1, b=0x100 -> 0x100*(i+1)).
//  4 FIXED_PRIO=1, req=4'b1010 held -> gnt[1] every cycle, req[3] never granted.
//  5 grants in cycles 20,21; reset_n low in 22 for 1 cycle -> no rsp_valid after release,
//    outputs 0 during reset, issue_count=0, next grant from req=4'b1111 goes to index 0.
//  6 issue_count preloaded to 0xFFFFFFFF via 2^32 grants (or force) + one grant -> 0; grant with
//    cnt_clear same cycle -> 0.

Source files
------------

// File: rtl/nios_system_mult_arbiter_if.sv
// rtl/nios_system_mult_arbiter_if.sv - requester-side request/grant/response bundle for the multiply arbiter
interface nios_system_mult_arbiter_if #(
   parameter int NUM_REQ = 4
);
   logic [NUM_REQ-1:0]    req;
   logic [32*NUM_REQ-1:0] req_a;
   logic [32*NUM_REQ-1:0] req_b;
   logic [NUM_REQ-1:0]    gnt;
   logic [NUM_REQ-1:0]    rsp_valid;
   logic [31:0]           rsp_data;

   modport master (
      output req, req_a, req_b,
      input  gnt, rsp_valid, rsp_data
   );

   modport slave (
      input  req, req_a, req_b,
      output gnt, rsp_valid, rsp_data
   );
endinterface

// File: rtl/nios_system_mult_arbiter.sv
// rtl/nios_system_mult_arbiter.sv - round-robin / fixed-priority sequencer sharing one pipelined 32x32 multiply cell
module nios_system_mult_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int MUL_LATENCY = 1,
   parameter int FIXED_PRIO  = 0
) (
   input  logic                       clk,
   input  logic                       reset_n,
   nios_system_mult_arbiter_if.slave  bus,
   output logic [31:0]                mul_src1,
   output logic [31:0]                mul_src2,
   input  logic [31:0]                mul_result,
   input  logic                       cnt_clear,
   output logic [31:0]                issue_count
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int SUM_W = PTR_W + 1;
   localparam logic [SUM_W-1:0] NUM_REQ_S = SUM_W'(NUM_REQ);
   localparam logic [PTR_W-1:0] PTR_RST   = PTR_W'(NUM_REQ - 1);

   logic [PTR_W-1:0]                    rr_ptr;
   logic [PTR_W-1:0]                    win_idx;
   logic [PTR_W-1:0]                    cand;
   logic [SUM_W-1:0]                    sum;
   logic                                found;
   logic [NUM_REQ-1:0]                  gnt_c;
   logic [NUM_REQ-1:0]                  rsp_v;
   logic [31:0]                         win_a;
   logic [31:0]                         win_b;
   logic [MUL_LATENCY:0][NUM_REQ-1:0]   tag_pipe;

   // Search starts one past the last winner; wrap is done in SUM_W bits so
   // non-power-of-two NUM_REQ still rotates modulo NUM_REQ.
   always_comb begin
      found   = 1'b0;
      win_idx = '0;
      cand    = '0;
      sum     = '0;
      gnt_c   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         sum = {1'b0, rr_ptr} + SUM_W'(k + 1);
         if (sum >= NUM_REQ_S) begin
            sum = sum - NUM_REQ_S;
         end
         cand = (FIXED_PRIO != 0) ? PTR_W'(k) : sum[PTR_W-1:0];
         if (!found && bus.req[cand]) begin
            found   = 1'b1;
            win_idx = cand;
         end
      end
      if (found && reset_n) begin
         gnt_c = NUM_REQ'(1) << win_idx;
      end
   end

   always_comb begin
      win_a = '0;
      win_b = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt_c[i]) begin
            win_a = bus.req_a[32*i +: 32];
            win_b = bus.req_b[32*i +: 32];
         end
      end
   end

   // Operands only move on a grant so the cell inputs do not toggle when idle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mul_src1 <= '0;
         mul_src2 <= '0;
         rr_ptr   <= PTR_RST;
      end else if (|gnt_c) begin
         mul_src1 <= win_a;
         mul_src2 <= win_b;
         rr_ptr   <= win_idx;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tag_pipe <= '0;
      end else begin
         tag_pipe[0] <= gnt_c;
         for (int i = 1; i <= MUL_LATENCY; i++) begin
            tag_pipe[i] <= tag_pipe[i-1];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         issue_count <= '0;
      end else if (cnt_clear) begin
         issue_count <= '0;
      end else if (|gnt_c) begin
         issue_count <= issue_count + 32'd1;
      end
   end

   assign rsp_v         = reset_n ? tag_pipe[MUL_LATENCY] : '0;
   assign bus.gnt       = gnt_c;
   assign bus.rsp_valid = rsp_v;
   assign bus.rsp_data  = (|rsp_v) ? mul_result : 32'd0;

endmodule

// File: tb/tb_nios_system_mult_arbiter.sv
// tb/tb_nios_system_mult_arbiter.sv - self-checking bench for nios_system_mult_arbiter (round-robin and fixed-priority)
module tb_nios_system_mult_arbiter;

   localparam int N    = 4;
   localparam int LAT  = 1;
   localparam int RING = 8;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        cnt_clear;
   logic [31:0] rr_src1, rr_src2, rr_cell, rr_cnt;
   logic [31:0] fp_src1, fp_src2, fp_cell, fp_cnt;

   nios_system_mult_arbiter_if #(.NUM_REQ(N)) rbus ();
   nios_system_mult_arbiter_if #(.NUM_REQ(N)) fbus ();

   assign fbus.req   = rbus.req;
   assign fbus.req_a = rbus.req_a;
   assign fbus.req_b = rbus.req_b;

   nios_system_mult_arbiter #(.NUM_REQ(N), .MUL_LATENCY(LAT), .FIXED_PRIO(0)) dut_rr (
      .clk(clk), .reset_n(reset_n), .bus(rbus),
      .mul_src1(rr_src1), .mul_src2(rr_src2), .mul_result(rr_cell),
      .cnt_clear(cnt_clear), .issue_count(rr_cnt)
   );

   nios_system_mult_arbiter #(.NUM_REQ(N), .MUL_LATENCY(LAT), .FIXED_PRIO(1)) dut_fp (
      .clk(clk), .reset_n(reset_n), .bus(fbus),
      .mul_src1(fp_src1), .mul_src2(fp_src2), .mul_result(fp_cell),
      .cnt_clear(cnt_clear), .issue_count(fp_cnt)
   );

   always #5 clk = ~clk;

   // One-stage multiply cell, low 32 bits
   always @(posedge clk) begin
      rr_cell <= rr_src1 * rr_src2;
      fp_cell <= fp_src1 * fp_src2;
   end

   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   int          mptr;
   int          last_win;
   logic [31:0] mcnt_rr, mcnt_fp;
   logic [N-1:0] ring_v_rr [RING];
   logic [N-1:0] ring_v_fp [RING];
   logic [31:0]  ring_d_rr [RING];
   logic [31:0]  ring_d_fp [RING];
   logic [N-1:0] obs_gnt_rr, obs_gnt_fp, obs_v_rr;
   logic [31:0]  obs_d_rr, obs_cnt_rr;
   logic [N-1:0] pend;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic int rr_pick(input logic [N-1:0] r, input int ptr);
      for (int k = 1; k <= N; k++) begin
         if (r[(ptr + k) % N]) return (ptr + k) % N;
      end
      return -1;
   endfunction

   function automatic int fp_pick(input logic [N-1:0] r);
      for (int i = 0; i < N; i++) begin
         if (r[i]) return i;
      end
      return -1;
   endfunction

   function automatic logic [31:0] prod(input logic [31:0] a, input logic [31:0] b);
      logic [63:0] full;
      full = 64'(a) * 64'(b);
      return full[31:0];
   endfunction

   function automatic logic [31:0] rand_op();
      case ($urandom_range(3, 0))
         0:       return 32'hFFFF_FFFF;
         1:       return 32'($urandom_range(15, 0));
         default: return $urandom;
      endcase
   endfunction

   task automatic clear_model();
      for (int i = 0; i < RING; i++) begin
         ring_v_rr[i] = '0; ring_v_fp[i] = '0;
         ring_d_rr[i] = '0; ring_d_fp[i] = '0;
      end
      mptr    = N - 1;
      mcnt_rr = '0;
      mcnt_fp = '0;
   endtask

   task automatic drive(input int i, input logic [31:0] a, input logic [31:0] b);
      rbus.req[i]            = 1'b1;
      rbus.req_a[32*i +: 32] = a;
      rbus.req_b[32*i +: 32] = b;
   endtask

   // Called #1 after a rising edge with inputs already applied.
   task automatic step_cycle();
      int wr, wf, slot, due;
      logic [N-1:0] eg;
      @(negedge clk);
      wr   = rr_pick(rbus.req, mptr);
      wf   = fp_pick(rbus.req);
      slot = cyc % RING;
      due  = (cyc + 1 + LAT) % RING;
      obs_gnt_rr = rbus.gnt;
      obs_gnt_fp = fbus.gnt;
      obs_v_rr   = rbus.rsp_valid;
      obs_d_rr   = rbus.rsp_data;
      obs_cnt_rr = rr_cnt;
      eg = (wr >= 0) ? N'(1) << wr : '0;
      check("gnt_rr", 32'(rbus.gnt), 32'(eg));
      eg = (wf >= 0) ? N'(1) << wf : '0;
      check("gnt_fp", 32'(fbus.gnt), 32'(eg));
      check("rspv_rr", 32'(rbus.rsp_valid), 32'(ring_v_rr[slot]));
      check("rspd_rr", rbus.rsp_data, ring_d_rr[slot]);
      check("rspv_fp", 32'(fbus.rsp_valid), 32'(ring_v_fp[slot]));
      check("rspd_fp", fbus.rsp_data, ring_d_fp[slot]);
      check("cnt_rr", rr_cnt, mcnt_rr);
      check("cnt_fp", fp_cnt, mcnt_fp);
      ring_v_rr[slot] = '0; ring_d_rr[slot] = '0;
      ring_v_fp[slot] = '0; ring_d_fp[slot] = '0;
      if (wr >= 0) begin
         ring_v_rr[due] = N'(1) << wr;
         ring_d_rr[due] = prod(rbus.req_a[32*wr +: 32], rbus.req_b[32*wr +: 32]);
         mptr = wr;
      end
      if (wf >= 0) begin
         ring_v_fp[due] = N'(1) << wf;
         ring_d_fp[due] = prod(rbus.req_a[32*wf +: 32], rbus.req_b[32*wf +: 32]);
      end
      mcnt_rr  = cnt_clear ? 32'd0 : (wr >= 0) ? mcnt_rr + 32'd1 : mcnt_rr;
      mcnt_fp  = cnt_clear ? 32'd0 : (wf >= 0) ? mcnt_fp + 32'd1 : mcnt_fp;
      last_win = wr;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic apply_reset();
      reset_n  = 1'b0;
      rbus.req = '1;
      @(negedge clk);
      check("rst_gnt_rr", 32'(rbus.gnt), 32'd0);
      check("rst_gnt_fp", 32'(fbus.gnt), 32'd0);
      check("rst_rspv", 32'(rbus.rsp_valid), 32'd0);
      check("rst_rspd", rbus.rsp_data, 32'd0);
      check("rst_cnt", rr_cnt, 32'd0);
      check("rst_src1", rr_src1, 32'd0);
      check("rst_src2", rr_src2, 32'd0);
      @(posedge clk);
      #1;
      reset_n  = 1'b1;
      rbus.req = '0;
      clear_model();
      cyc++;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n    = 1'b0;
      cnt_clear  = 1'b0;
      rbus.req   = '0;
      rbus.req_a = '0;
      rbus.req_b = '0;
      pend       = '0;
      clear_model();
      repeat (2) @(posedge clk);
      #1;
      apply_reset();

      // single op: 3*5
      drive(0, 32'd3, 32'd5);
      step_cycle();
      check("t1_gnt", 32'(obs_gnt_rr), 32'd1);
      rbus.req = '0;
      step_cycle();
      check("t1_cnt", obs_cnt_rr, 32'd1);
      step_cycle();
      check("t1_rspv", 32'(obs_v_rr), 32'd1);
      check("t1_rspd", obs_d_rr, 32'd15);

      // modulo 2^32 products
      drive(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      step_cycle();
      rbus.req = '0;
      step_cycle();
      step_cycle();
      check("t2_rspv", 32'(obs_v_rr), 32'd2);
      check("t2_ones", obs_d_rr, 32'h0000_0001);
      drive(1, 32'h0001_2345, 32'h0001_0000);
      step_cycle();
      rbus.req = '0;
      step_cycle();
      step_cycle();
      check("t2_shift", obs_d_rr, 32'h2345_0000);

      // all four held: rotation 0,1,2,3,... with responses two cycles behind
      apply_reset();
      for (int i = 0; i < N; i++) drive(i, 32'(i + 1), 32'h100);
      for (int k = 0; k < 10; k++) begin
         if (k == 8) rbus.req = '0;
         step_cycle();
         if (k < 8) check("t3_gnt", 32'(obs_gnt_rr), 32'(1 << (k % N)));
         if (k >= 2) begin
            check("t3_rspv", 32'(obs_v_rr), 32'(1 << ((k - 2) % N)));
            check("t3_rspd", obs_d_rr, 32'h100 * 32'(((k - 2) % N) + 1));
         end
      end

      // fixed priority starves index 3
      rbus.req = '0;
      drive(1, 32'd6, 32'd7);
      drive(3, 32'd8, 32'd9);
      for (int k = 0; k < 6; k++) begin
         step_cycle();
         check("t4_fp_gnt", 32'(obs_gnt_fp), 32'd2);
      end
      rbus.req = '0;
      step_cycle();
      step_cycle();

      // reset with ops in flight
      drive(2, 32'd7, 32'd9);
      step_cycle();
      rbus.req = '0;
      drive(3, 32'd4, 32'd4);
      step_cycle();
      apply_reset();
      for (int i = 0; i < N; i++) drive(i, 32'(i + 10), 32'd3);
      step_cycle();
      check("t5_first", 32'(obs_gnt_rr), 32'd1);
      rbus.req = '0;
      step_cycle();
      step_cycle();

      // issue_count wrap and clear priority
      drive(0, 32'd2, 32'd2);
      force dut_rr.issue_count = 32'hFFFF_FFFF;
      #1;
      release dut_rr.issue_count;
      mcnt_rr = 32'hFFFF_FFFF;
      step_cycle();
      rbus.req = '0;
      step_cycle();
      check("t6_wrap", obs_cnt_rr, 32'd0);
      drive(0, 32'd2, 32'd2);
      cnt_clear = 1'b1;
      step_cycle();
      cnt_clear = 1'b0;
      rbus.req  = '0;
      step_cycle();
      check("t6_clr", obs_cnt_rr, 32'd0);
      step_cycle();

      // randomized traffic with holds, drops and counter clears
      for (int c = 0; c < 600; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!pend[i]) begin
               if ($urandom_range(1, 0) == 1) begin
                  pend[i] = 1'b1;
                  drive(i, rand_op(), rand_op());
               end
            end else if ($urandom_range(15, 0) == 0) begin
               pend[i]     = 1'b0;
               rbus.req[i] = 1'b0;
            end
         end
         cnt_clear = ($urandom_range(19, 0) == 0);
         step_cycle();
         if (last_win >= 0) begin
            pend[last_win]     = 1'b0;
            rbus.req[last_win] = 1'b0;
         end
      end
      rbus.req  = '0;
      cnt_clear = 1'b0;
      repeat (3) step_cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
